burst_period_timer: RTL and testbench
=====================================

BURST_PERIOD_TIMER -- requirements
Module: burst_period_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 48, setting the period register and down-counter width in clocks.
REQ-002 The block SHALL have parameter CNT_W, default 16, setting the burst-count width.
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-low, sampled on Clock rising edge.
REQ-005 The block SHALL have port Din, input, WIDTH bits: period value in clocks.
REQ-006 The block SHALL have port EN, input, 1 bit: when high, loads Din into the shadow period register.
REQ-007 The block SHALL have port Start, input, 1 bit: begins a burst when idle.
REQ-008 The block SHALL have port Stop, input, 1 bit: aborts a running burst.
REQ-009 The block SHALL have port Mode, input, 1 bit: 0 = N-period burst, 1 = continuous.
REQ-010 The block SHALL have port BurstNum, input, CNT_W bits: number of periods in Mode 0.
REQ-011 The block SHALL have port Dout, output, WIDTH bits: shadow period register readback.
REQ-012 The block SHALL have port Tick, output, 1 bit: registered one-cycle pulse at each period end.
REQ-013 The block SHALL have port Done, output, 1 bit: registered one-cycle pulse on natural burst completion.
REQ-014 The block SHALL have port Busy, output, 1 bit: high while state is RUN.
REQ-015 The block SHALL have port TickCnt, output, CNT_W bits: number of periods completed in the current or last burst.

Function
REQ-016 The block SHALL implement a two-state FSM with states IDLE and RUN.
REQ-017 The shadow register SHALL take Din on any edge with EN=1, in any state, and SHALL otherwise hold; Dout SHALL equal the shadow register.
REQ-018 The effective period SHALL be Din when EN=1 on the same edge, and the shadow register otherwise.
REQ-019 On IDLE with Start=1 and effective period P≠0, the block SHALL do all of the following:
- load the active period with P and the down-counter with P-1;
- latch Mode and BurstNum;
- clear TickCnt;
- enter RUN.
REQ-020 On IDLE with Start=1 and effective period 0, Start SHALL be ignored and the block SHALL remain in IDLE.
REQ-021 In RUN, the down-counter SHALL decrement by 1 per clock while non-zero.
REQ-022 In RUN, on the edge where the counter equals 0, the block SHALL do all of the following:
- assert Tick for one cycle;
- increment TickCnt, wrapping modulo 2^CNT_W;
- reload the active period from the shadow register, and the counter with active-1.
REQ-023 The first Tick SHALL occur exactly P clocks after the Start edge, and each later Tick exactly the active period after the previous Tick.
REQ-024 A shadow value written during RUN SHALL take effect only at the next period boundary, never mid-period.
REQ-025 If the shadow register is 0 at a boundary, the block SHALL keep the previous active period.
REQ-026 In latched Mode 0 with BurstNum≠0, on the boundary where TickCnt+1 equals BurstNum, the block SHALL assert Tick and Done on the same edge and return to IDLE.
REQ-027 Latched Mode 1, or Mode 0 with BurstNum=0, SHALL run continuously until Stop.
REQ-028 Stop=1 in RUN SHALL return the block to IDLE on that edge, with no Tick and no Done; Stop SHALL take priority over a simultaneous boundary.
REQ-029 Start in RUN SHALL be ignored, and Stop in IDLE SHALL be ignored.
REQ-030 TickCnt SHALL hold its final value in IDLE until the next accepted Start.
REQ-031 Busy SHALL be 1 exactly when state is RUN.
REQ-032 P=1 SHALL produce Tick on every clock while RUN.

Reset
REQ-033 While Reset=0 at a clock edge, the block SHALL clear the shadow register, active period, counter and TickCnt to 0, clear Tick, Done and Busy to 0, and enter IDLE; Reset SHALL take priority over EN, Start and Stop.
REQ-034 Reset asserted mid-burst SHALL abort the burst without a Tick or Done pulse.

Verification
REQ-035 EN=1 with Din=5, then Start with Mode=0 and BurstNum=3 -> Tick at 5, 10 and 15 clocks after Start, Done together with the third Tick, then Busy=0 and TickCnt=3.
REQ-036 Shadow=4, Mode=1; write Din=7 two clocks after Start -> Ticks at +4, +11 and +18, showing no mid-period change.
REQ-037 Shadow=0, Start -> Busy stays 0 and no Tick; also EN=1 with Din=3 and Start on the same edge -> first Tick at +3.
REQ-038 Shadow=6, Mode=1; Stop asserted on the boundary edge at +6 -> no Tick, no Done, Busy=0 after that edge.
REQ-039 Din=1, Start, Mode=0, BurstNum=4 -> Tick high for 4 consecutive cycles, Done on the 4th.
REQ-040 Reset=0 mid-burst with Shadow=8 -> Dout=0, Busy=0, TickCnt=0 and no pulses; a following Start is ignored until the shadow register is rewritten.

Source files
------------

// File: rtl/burst_period_timer.sv
// rtl/burst_period_timer.sv - shadow-buffered period timer producing N-period or continuous tick bursts
module burst_period_timer #(
   parameter int WIDTH = 48,
   parameter int CNT_W = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] Din,
   input  logic             EN,
   input  logic             Start,
   input  logic             Stop,
   input  logic             Mode,
   input  logic [CNT_W-1:0] BurstNum,
   output logic [WIDTH-1:0] Dout,
   output logic             Tick,
   output logic             Done,
   output logic             Busy,
   output logic [CNT_W-1:0] TickCnt
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] shadow_nxt;
   logic [WIDTH-1:0] active;
   logic [WIDTH-1:0] active_nxt;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_nxt;
   logic [CNT_W-1:0] tick_cnt;
   logic [CNT_W-1:0] tick_cnt_nxt;
   logic [CNT_W-1:0] tick_cnt_inc;
   logic [CNT_W-1:0] burst;
   logic [CNT_W-1:0] burst_nxt;
   logic             mode;
   logic             mode_nxt;
   logic             tick;
   logic             tick_nxt;
   logic             done;
   logic             done_nxt;
   logic [WIDTH-1:0] eff_period;
   logic [WIDTH-1:0] reload;

   // A write on the Start edge counts immediately; at boundaries only the stored shadow is used.
   assign eff_period   = EN ? Din : shadow;
   assign reload       = (shadow != '0) ? shadow : active;
   assign tick_cnt_inc = tick_cnt + 1'b1;

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state    <= IDLE;
         shadow   <= '0;
         active   <= '0;
         cnt      <= '0;
         tick_cnt <= '0;
         burst    <= '0;
         mode     <= 1'b0;
         tick     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         shadow   <= shadow_nxt;
         active   <= active_nxt;
         cnt      <= cnt_nxt;
         tick_cnt <= tick_cnt_nxt;
         burst    <= burst_nxt;
         mode     <= mode_nxt;
         tick     <= tick_nxt;
         done     <= done_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      shadow_nxt   = EN ? Din : shadow;
      active_nxt   = active;
      cnt_nxt      = cnt;
      tick_cnt_nxt = tick_cnt;
      burst_nxt    = burst;
      mode_nxt     = mode;
      tick_nxt     = 1'b0;
      done_nxt     = 1'b0;

      case (state)
         IDLE: begin
            if (Start && (eff_period != '0)) begin
               active_nxt   = eff_period;
               cnt_nxt      = eff_period - 1'b1;
               mode_nxt     = Mode;
               burst_nxt    = BurstNum;
               tick_cnt_nxt = '0;
               state_nxt    = RUN;
            end
         end
         RUN: begin
            // Stop wins over a coinciding period boundary: no pulse on abort.
            if (Stop) begin
               state_nxt = IDLE;
            end else if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               tick_nxt     = 1'b1;
               tick_cnt_nxt = tick_cnt_inc;
               active_nxt   = reload;
               cnt_nxt      = reload - 1'b1;
               if (!mode && (burst != '0) && (tick_cnt_inc == burst)) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign Dout    = shadow;
   assign Tick    = tick;
   assign Done    = done;
   assign Busy    = (state == RUN);
   assign TickCnt = tick_cnt;

endmodule

// File: tb/tb_burst_period_timer.sv
// tb/tb_burst_period_timer.sv - scoreboard bench: expected tick cycles queued at stimulus, checked as pulses appear
module tb_burst_period_timer;

   localparam int WIDTH = 48;
   localparam int CNT_W = 16;

   logic             Clock = 1'b0;
   logic             Reset = 1'b0;
   logic [WIDTH-1:0] Din = '0;
   logic             EN = 1'b0;
   logic             Start = 1'b0;
   logic             Stop = 1'b0;
   logic             Mode = 1'b0;
   logic [CNT_W-1:0] BurstNum = '0;
   logic [WIDTH-1:0] Dout;
   logic             Tick;
   logic             Done;
   logic             Busy;
   logic [CNT_W-1:0] TickCnt;

   typedef struct {
      int   cyc;
      logic done;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   tests_done = 1'b0;

   burst_period_timer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .Clock(Clock), .Reset(Reset), .Din(Din), .EN(EN), .Start(Start), .Stop(Stop),
      .Mode(Mode), .BurstNum(BurstNum), .Dout(Dout), .Tick(Tick), .Done(Done),
      .Busy(Busy), .TickCnt(TickCnt)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic push_tick(input int c, input logic d);
      exp_t e;
      e.cyc  = c;
      e.done = d;
      sb_q.push_back(e);
   endtask

   task automatic test_reset();
      Reset = 1'b0; EN = 1'b1; Din = 48'd9; Start = 1'b1;
      step(2);
      vectors++;
      if (Dout !== '0 || Busy !== 1'b0 || TickCnt !== '0 || Tick !== 1'b0 || Done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: Dout=%0d Busy=%b TickCnt=%0d Tick=%b Done=%b required all 0",
                  Dout, Busy, TickCnt, Tick, Done);
      end
      Reset = 1'b1; EN = 1'b0; Start = 1'b0;
      step(1);
   endtask

   task automatic test_n_burst();
      int s;
      EN = 1'b1; Din = 48'd5;
      step(1);
      EN = 1'b0; Start = 1'b1; Mode = 1'b0; BurstNum = 16'd3;
      s = cyc + 1;
      push_tick(s + 5, 1'b0); push_tick(s + 10, 1'b0); push_tick(s + 15, 1'b1);
      step(1);
      Start = 1'b0;
      vectors++;
      if (Busy !== 1'b1) begin
         miscompares++;
         $display("FAIL burst_busy: Busy=%b required 1", Busy);
      end
      step(6);
      Start = 1'b1;
      step(1);
      Start = 1'b0;
      step(13);
      vectors++;
      if (Busy !== 1'b0 || TickCnt !== 16'd3 || sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL burst_end: Busy=%b TickCnt=%0d pending=%0d required 0/3/0", Busy, TickCnt, sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_shadow_update();
      int s;
      EN = 1'b1; Din = 48'd4;
      step(1);
      EN = 1'b0; Start = 1'b1; Mode = 1'b1;
      s = cyc + 1;
      push_tick(s + 4, 1'b0); push_tick(s + 11, 1'b0); push_tick(s + 18, 1'b0);
      step(1);
      Start = 1'b0;
      step(1);
      EN = 1'b1; Din = 48'd7;
      step(1);
      EN = 1'b0;
      step(18);
      Stop = 1'b1;
      step(1);
      Stop = 1'b0;
      vectors++;
      if (Busy !== 1'b0 || TickCnt !== 16'd3 || Dout !== 48'd7 || sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL shadow_update: Busy=%b TickCnt=%0d Dout=%0d pending=%0d required 0/3/7/0",
                  Busy, TickCnt, Dout, sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_zero_period();
      int s;
      EN = 1'b1; Din = '0;
      step(1);
      EN = 1'b0; Start = 1'b1; Mode = 1'b0; BurstNum = 16'd1;
      step(1);
      Start = 1'b0;
      vectors++;
      if (Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_start: Busy=%b required 0", Busy);
      end
      step(5);
      EN = 1'b1; Din = 48'd3; Start = 1'b1;
      s = cyc + 1;
      push_tick(s + 3, 1'b1);
      step(1);
      EN = 1'b0; Start = 1'b0;
      step(5);
      vectors++;
      if (Busy !== 1'b0 || TickCnt !== 16'd1 || Dout !== 48'd3 || sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL same_edge_load: Busy=%b TickCnt=%0d Dout=%0d pending=%0d required 0/1/3/0",
                  Busy, TickCnt, Dout, sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_stop_boundary();
      EN = 1'b1; Din = 48'd6;
      step(1);
      EN = 1'b0; Start = 1'b1; Mode = 1'b1;
      step(1);
      Start = 1'b0;
      step(5);
      Stop = 1'b1;
      step(1);
      Stop = 1'b0;
      vectors++;
      if (Busy !== 1'b0 || Tick !== 1'b0 || Done !== 1'b0 || TickCnt !== '0) begin
         miscompares++;
         $display("FAIL stop_boundary: Busy=%b Tick=%b Done=%b TickCnt=%0d required all 0",
                  Busy, Tick, Done, TickCnt);
      end
      Stop = 1'b1;
      step(1);
      Stop = 1'b0;
      step(4);
      vectors++;
      if (Busy !== 1'b0 || sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL stop_idle: Busy=%b pending=%0d required 0/0", Busy, sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_period_one();
      int s;
      EN = 1'b1; Din = 48'd1;
      step(1);
      EN = 1'b0; Start = 1'b1; Mode = 1'b0; BurstNum = 16'd4;
      s = cyc + 1;
      for (int i = 1; i <= 4; i++) push_tick(s + i, (i == 4));
      step(1);
      Start = 1'b0;
      step(7);
      vectors++;
      if (Busy !== 1'b0 || TickCnt !== 16'd4 || sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL period_one: Busy=%b TickCnt=%0d pending=%0d required 0/4/0", Busy, TickCnt, sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_continuous_keep();
      int s;
      EN = 1'b1; Din = 48'd2;
      step(1);
      EN = 1'b0; Start = 1'b1; Mode = 1'b0; BurstNum = '0;
      s = cyc + 1;
      for (int i = 1; i <= 4; i++) push_tick(s + 2 * i, 1'b0);
      step(1);
      Start = 1'b0; EN = 1'b1; Din = '0;
      step(1);
      EN = 1'b0;
      step(7);
      Stop = 1'b1;
      step(1);
      Stop = 1'b0;
      vectors++;
      if (Busy !== 1'b0 || TickCnt !== 16'd4 || Dout !== '0 || sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL continuous_keep: Busy=%b TickCnt=%0d Dout=%0d pending=%0d required 0/4/0/0",
                  Busy, TickCnt, Dout, sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_reset_midburst();
      int s;
      EN = 1'b1; Din = 48'd8;
      step(1);
      EN = 1'b0; Start = 1'b1; Mode = 1'b1;
      s = cyc + 1;
      push_tick(s + 8, 1'b0);
      step(1);
      Start = 1'b0;
      step(9);
      Reset = 1'b0;
      step(1);
      Reset = 1'b1;
      vectors++;
      if (Dout !== '0 || Busy !== 1'b0 || TickCnt !== '0 || Tick !== 1'b0 || Done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_midburst: Dout=%0d Busy=%b TickCnt=%0d Tick=%b Done=%b required all 0",
                  Dout, Busy, TickCnt, Tick, Done);
      end
      Start = 1'b1;
      step(1);
      Start = 1'b0;
      vectors++;
      if (Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL start_after_reset: Busy=%b required 0", Busy);
      end
      step(10);
      EN = 1'b1; Din = 48'd2;
      step(1);
      EN = 1'b0; Start = 1'b1;
      s = cyc + 1;
      push_tick(s + 2, 1'b0);
      step(1);
      Start = 1'b0;
      vectors++;
      if (Busy !== 1'b1) begin
         miscompares++;
         $display("FAIL restart_busy: Busy=%b required 1", Busy);
      end
      step(2);
      Stop = 1'b1;
      step(1);
      Stop = 1'b0;
      vectors++;
      if (Busy !== 1'b0 || TickCnt !== 16'd1 || sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL restart_end: Busy=%b TickCnt=%0d pending=%0d required 0/1/0", Busy, TickCnt, sb_q.size());
      end
      sb_q.delete();
   endtask

   initial begin
      fork
         begin
            exp_t e;
            while (!tests_done) begin
               @(negedge Clock);
               if (Tick || Done || (sb_q.size() > 0 && sb_q[0].cyc == cyc)) begin
                  vectors++;
                  if (sb_q.size() == 0) begin
                     miscompares++;
                     $display("FAIL unexpected_pulse: cyc=%0d Tick=%b Done=%b required no pulse", cyc, Tick, Done);
                  end else begin
                     e = sb_q.pop_front();
                     if (cyc != e.cyc || Tick !== 1'b1 || Done !== e.done) begin
                        miscompares++;
                        $display("FAIL tick_event: cyc=%0d Tick=%b Done=%b required cyc=%0d Tick=1 Done=%b",
                                 cyc, Tick, Done, e.cyc, e.done);
                     end
                  end
               end
            end
         end
         begin
            test_reset();
            test_n_burst();
            test_shadow_update();
            test_zero_period();
            test_stop_boundary();
            test_period_one();
            test_continuous_keep();
            test_reset_midburst();
            step(2);
            tests_done = 1'b1;
         end
      join
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
